// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that merges per-key press strobes into an ordered event FIFO.
// Optional KEY_ARB_DROP_CNT_EN adds an 8-bit saturating drop counter output.
module key_event_arbiter #(
  parameter int unsigned N_KEYS     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_KEYS-1:0]           key_stb_i,
  output logic                        evt_valid_o,
  output logic [$clog2(N_KEYS)-1:0]   evt_key_o,
  input  logic                        evt_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        drop_o
`ifdef KEY_ARB_DROP_CNT_EN
  ,
  output logic [7:0]                  drop_cnt_o
`endif
);

  localparam int unsigned KW = $clog2(N_KEYS);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [N_KEYS-1:0] pending_q;
  logic [KW-1:0]     last_grant_q;
  logic [KW-1:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              drop_q;

  logic              full;
  logic              push;
  logic              pop;
  logic [KW-1:0]     grant_idx;
  logic [N_KEYS-1:0] grant_mask;
  logic [N_KEYS-1:0] pending_rot;
  int unsigned       search_idx;

  assign full        = (count_q == CW'(FIFO_DEPTH));
  assign pop         = (count_q != '0) && evt_ready_i;
  assign evt_valid_o = (count_q != '0);
  assign evt_key_o   = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign drop_o      = drop_q;

  // Search upward from last_grant+1; a full queue blocks grants even if it pops this cycle.
  always_comb begin
    push        = 1'b0;
    grant_idx   = '0;
    grant_mask  = '0;
    search_idx  = 0;
    pending_rot = '0;
    for (int unsigned i = 1; i <= N_KEYS; i++) begin
      search_idx  = (32'(last_grant_q) + i) % N_KEYS;
      pending_rot = pending_q >> search_idx;
      if (!push && !full && pending_rot[0]) begin
        push      = 1'b1;
        grant_idx = KW'(search_idx);
      end
    end
    if (push) begin
      grant_mask = N_KEYS'(1) << grant_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q    <= '0;
      last_grant_q <= KW'(N_KEYS - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      drop_q       <= 1'b0;
    end else begin
      // A strobe landing on its own grant-clear re-arms the flag.
      pending_q <= (pending_q & ~grant_mask) | key_stb_i;
      drop_q    <= |(key_stb_i & pending_q & ~grant_mask);
      if (push) begin
        last_grant_q <= grant_idx;
        wr_ptr_q     <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      mem_q[wr_ptr_q] <= grant_idx;
    end
  end

`ifdef KEY_ARB_DROP_CNT_EN
  logic [7:0] drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      drop_cnt_q <= '0;
    end else if (drop_q && (drop_cnt_q != 8'hff)) begin
      drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
`endif

endmodule

// File: tb/tb_key_event_arbiter.sv
// Randomized and directed bench for key_event_arbiter against a queue-based reference model.
module tb_key_event_arbiter;

  localparam int unsigned NK = 4;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] stb;
  logic          ready;
  logic          evt_valid;
  logic [1:0]    evt_key;
  logic [2:0]    count;
  logic          drop;
`ifdef KEY_ARB_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  always #5 clk = ~clk;

  key_event_arbiter #(
    .N_KEYS     (NK),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .key_stb_i   (stb),
    .evt_valid_o (evt_valid),
    .evt_key_o   (evt_key),
    .evt_ready_i (ready),
    .count_o     (count),
    .drop_o      (drop)
`ifdef KEY_ARB_DROP_CNT_EN
    ,
    .drop_cnt_o  (drop_cnt)
`endif
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: event queue, pending set, round-robin pointer.
  int mq[$];
  bit mpend[NK];
  int mlast;
  bit mdrop;
  int mdcnt;
  int got[$];

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    mq.delete();
    for (int k = 0; k < NK; k++) mpend[k] = 1'b0;
    mlast = NK - 1;
    mdrop = 1'b0;
    mdcnt = 0;
  endtask

  task automatic check_outputs();
    check_val("valid", evt_valid, (mq.size() > 0) ? 1 : 0);
    check_val("count", count, mq.size());
    check_val("drop", drop, mdrop);
    if (mq.size() > 0) check_val("key", evt_key, mq[0]);
`ifdef KEY_ARB_DROP_CNT_EN
    check_val("drop_cnt", drop_cnt, mdcnt);
`endif
  endtask

  task automatic step(input logic [NK-1:0] s, input logic r, input logic rs);
    int  g;
    int  k;
    bit  found;
    stb   = s;
    ready = r;
    rst   = rs;
    if (rs) begin
      model_reset();
    end else begin
      if (mdrop && mdcnt < 255) mdcnt++;
      g     = -1;
      found = 1'b0;
      if (mq.size() < FD) begin
        for (int i = 1; i <= NK; i++) begin
          k = (mlast + i) % NK;
          if (!found && mpend[k]) begin
            found = 1'b1;
            g     = k;
          end
        end
      end
      mdrop = 1'b0;
      for (int j = 0; j < NK; j++) if (s[j] && mpend[j] && j != g) mdrop = 1'b1;
      if (mq.size() > 0 && r) void'(mq.pop_front());
      if (found) begin
        mq.push_back(g);
        mpend[g] = 1'b0;
        mlast    = g;
      end
      for (int j = 0; j < NK; j++) if (s[j]) mpend[j] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic check_seq(input string tag, input int exp[$]);
    check_val({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      check_val({tag, "_evt"}, (i < got.size()) ? got[i] : 99, exp[i]);
    end
  endtask

  task automatic drain(input int cycles);
    got.delete();
    for (int i = 0; i < cycles; i++) begin
      if (evt_valid) got.push_back(int'(evt_key));
      step('0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    stb   = '0;
    ready = 1'b0;
    rst   = 1'b1;
    model_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b1);
    check_val("rst_valid", evt_valid, 0);
    check_val("rst_count", count, 0);
    check_val("rst_drop", drop, 0);

    // Single strobe on key 2: valid exactly two edges later, for one cycle.
    step(4'b0100, 1'b1, 1'b0);
    check_val("s29_early", evt_valid, 0);
    step('0, 1'b1, 1'b0);
    check_val("s29_valid", evt_valid, 1);
    check_val("s29_key", evt_key, 2);
    step('0, 1'b1, 1'b0);
    check_val("s29_count", count, 0);

    // All keys at once after reset.
    step('0, 1'b0, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    drain(6);
    check_seq("s30", '{0, 1, 2, 3});

    // Fill with ready low, two keys remain pending, then drain in order.
    step('0, 1'b0, 1'b1);
    foreach (got[i]) got[i] = 0;
    begin
      int keys[6] = '{0, 1, 2, 3, 0, 1};
      for (int i = 0; i < 6; i++) begin
        step(NK'(1) << keys[i], 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
        step('0, 1'b0, 1'b0);
      end
    end
    check_val("s31_full", count, 4);
    drain(10);
    check_seq("s31", '{0, 1, 2, 3, 0, 1});

    // Double strobe on key 1 against a full queue.
    step('0, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step('0, 1'b0, 1'b0);
    check_val("s32_full", count, 4);
    step(4'b0010, 1'b0, 1'b0);
    check_val("s32_nodrop", drop, 0);
    step(4'b0010, 1'b0, 1'b0);
    check_val("s32_drop", drop, 1);
    step('0, 1'b0, 1'b0);
    check_val("s32_drop_end", drop, 0);
`ifdef KEY_ARB_DROP_CNT_EN
    check_val("s32_drop_cnt", drop_cnt, 1);
`endif
    drain(8);
    check_seq("s32", '{0, 1, 2, 3, 1});

    // Mid-operation reset with occupancy 3 and a pending flag.
    step('0, 1'b0, 1'b1);
    step(4'b0111, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step('0, 1'b0, 1'b0);
    step(4'b1000, 1'b0, 1'b0);
    check_val("s33_count", count, 3);
    step(4'b1111, 1'b1, 1'b1);
    check_val("s33_valid", evt_valid, 0);
    check_val("s33_cnt0", count, 0);
    step(4'b1000, 1'b1, 1'b0);
    step('0, 1'b1, 1'b0);
    check_val("s33_key", evt_key, 3);
    check_val("s33_kvalid", evt_valid, 1);

    // Random traffic with varying consumer pressure and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      logic [NK-1:0] s;
      for (int j = 0; j < NK; j++) s[j] = ($urandom_range(0, 3) == 0);
      step(s, (i % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_event_arbiter.md
KEY_EVENT_ARBITER -- requirements
Module: key_event_arbiter

Interface
REQ-001 SHALL have parameter N_KEYS, default 4, number of debounced key strobe inputs; legal range 2..16.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, event queue depth; power of two, legal range 2..16.
REQ-003 SHALL have port clk_i  input  1  the only clock; all logic on posedge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port key_stb_i  input  N_KEYS  one-cycle press strobes, one bit per key debouncer.
REQ-006 SHALL have port evt_valid_o  output  1  queue head holds a valid event.
REQ-007 SHALL have port evt_key_o  output  $clog2(N_KEYS)  key index of the queue head.
REQ-008 SHALL have port evt_ready_i  input  1  consumer accepts the head event.
REQ-009 SHALL have port count_o  output  $clog2(FIFO_DEPTH)+1  current queue occupancy.
REQ-010 SHALL have port drop_o  output  1  registered one-cycle pulse on a merged (lost) strobe.

Function
REQ-011 SHALL keep one pending flag per key; key_stb_i[k]=1 at an edge sets pending[k] at that edge.
REQ-012 SHALL, each cycle with any pending flag set and count_o<FIFO_DEPTH, grant exactly one key combinationally from the registered pending flags.
REQ-013 SHALL select the grant round-robin: the first pending key searching upward from (last_grant+1) mod N_KEYS; last_grant updates only on a grant.
REQ-014 SHALL, at the edge ending a grant cycle, push the granted index into the queue and clear that pending flag.
REQ-015 SHALL keep pending[k]=1 when a strobe for key k coincides with its grant-clear (the new strobe wins).
REQ-016 SHALL, on a strobe for key k with pending[k]=1 and key k not granted that cycle, keep one pending flag and assert drop_o for the following cycle only.
REQ-017 SHALL suppress grants while count_o==FIFO_DEPTH, even if a pop occurs in the same cycle; pending flags are held.
REQ-018 SHALL drive evt_valid_o=1 whenever count_o>0, with evt_key_o equal to the oldest queued index.
REQ-019 SHALL pop on an edge where evt_valid_o && evt_ready_i; evt_key_o SHALL stay stable while evt_valid_o && !evt_ready_i.
REQ-020 SHALL update count_o as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 SHALL give a latency of 2 edges from strobe to evt_valid_o on an idle empty queue: strobe sampled at E0, push at E1, valid after E1.
REQ-022 SHALL wrap queue read and write pointers modulo FIFO_DEPTH without losing or duplicating entries.
REQ-023 SHALL leave evt_key_o unspecified while evt_valid_o=0; the bench SHALL not check it then.

Reset
REQ-024 SHALL, when rst_i=1 at an edge, clear all pending flags, queue pointers and count_o to 0, set last_grant to N_KEYS-1 so key 0 has first priority, and set drop_o to 0.
REQ-025 SHALL ignore key_stb_i and evt_ready_i at any edge where rst_i=1, including a reset asserted mid-operation with a full queue.
REQ-026 SHALL give outputs after reset of evt_valid_o=0, count_o=0, drop_o=0.

Configuration
REQ-027 SHALL, with macro KEY_ARB_DROP_CNT_EN defined, add output drop_cnt_o (8 bits), incremented on each drop_o pulse, saturating at 255 and cleared by rst_i.
REQ-028 SHALL, without KEY_ARB_DROP_CNT_EN, omit the drop_cnt_o port and its logic; all other behaviour SHALL be identical.

Verification
REQ-029 SHALL cover this scenario: single strobe on key 2, ready=1 -> evt_valid_o high exactly 2 edges later with evt_key_o=2 for one cycle, then count_o=0.
REQ-030 SHALL cover this scenario: key_stb_i=4'b1111 in one cycle after reset, ready=1 -> events 0,1,2,3 on consecutive cycles, drop_o never asserted.
REQ-031 SHALL cover this scenario: ready=0 and 6 distinct strobes on keys 0,1,2,3,0,1 spaced 3 cycles apart -> count_o saturates at 4, keys 0 and 1 stay pending; after ready=1 the order is 0,1,2,3,0,1.
REQ-032 SHALL cover this scenario: key 1 strobed twice while pending with a full queue -> drop_o pulses once and drop_cnt_o=1 (macro on); a single key-1 event remains queued-pending.
REQ-033 SHALL cover this scenario: rst_i asserted for 1 cycle with count_o=3 and pending flags set -> next cycle evt_valid_o=0, count_o=0; a subsequent strobe on key 3 yields evt_key_o=3 after 2 edges.
